fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the control unit. Holds the PC, fetches one 32-bit

---
 rtl/mips_pkg.sv | 25 ++
 rtl/next_pc_calc.sv | 32 +++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants and fetch-state encoding for the fetch/decode front end.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FULL = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump target over branch target over sequential pc+4.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [31:0]       instr,
  input  logic              pc_src,
  input  logic              jump,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jmp_tgt;
  logic              unused_opcode;

  // Word offset sign-extended and scaled by 4; the add wraps naturally at ADDR_W bits.
  assign br_off  = {{(ADDR_W-18){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO], 2'b00};
  assign jmp_tgt = {pc_plus4[ADDR_W-1:28], instr[TARGET_HI:TARGET_LO], 2'b00};
  assign unused_opcode = ^instr[OPCODE_HI:OPCODE_LO];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jmp_tgt;
    end else if (pc_src) begin
      next_pc = pc_plus4 + br_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem fetch, holds the instruction until decode accepts it.
// Optional FETCH_STATS_EN adds fetch_count / redirect_count outputs.
//
// state   | meaning
// IDLE    | no fetch in flight; waits for halt=0
// REQ     | request presented at pc, held until imem accepts
// WAIT    | request accepted, waiting for the single response
// FULL    | instr holds a word for decode; accept picks next pc
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              pc_src,
  input  logic              jump
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       redirect_count
`endif
);

  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              capture;
  logic              accept;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .pc_src   (pc_src),
    .jump     (jump),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    capture        = 1'b0;
    accept         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!halt) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // halt is deliberately not looked at here: a presented request must complete
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          capture   = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          accept    = 1'b1;
          state_nxt = halt ? ST_IDLE : ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc     <= RST_PC;
      pc_out <= RST_PC;
      instr  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        instr  <= imem_rsp_data;
        pc_out <= pc;
      end
      if (accept) pc <= next_pc;
    end
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc_out + ADDR_W'(4);
  assign opcode    = instr[OPCODE_HI:OPCODE_LO];
  assign func      = instr[FUNC_HI:FUNC_LO];

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count    <= 32'h0;
      redirect_count <= 32'h0;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'h1;
      if (jump || pc_src) redirect_count <= redirect_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances with different RESET_PC share one stimulus stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_ready = 1'b0;
  logic        pc_src = 1'b0;
  logic        jump = 1'b0;

  logic        req_valid [3];
  logic [31:0] addr      [3];
  logic        ivalid    [3];
  logic [31:0] instr     [3];
  logic [5:0]  opcode    [3];
  logic [5:0]  func      [3];
  logic [31:0] pc_out    [3];
  logic [31:0] pc_plus4  [3];
`ifdef FETCH_STATS_EN
  logic [31:0] fcnt [3];
  logic [31:0] rcnt [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [31:0] RPC = (g == 0) ? 32'h0000_0000 :
                                  (g == 1) ? 32'h4000_0000 : 32'hFFFF_FFFC;
    fetch_unit #(.RESET_PC(RPC), .ADDR_W(32)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .halt           (halt),
      .imem_req_valid (req_valid[g]),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (addr[g]),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (ivalid[g]),
      .instr_ready    (instr_ready),
      .instr          (instr[g]),
      .opcode         (opcode[g]),
      .func           (func[g]),
      .pc_out         (pc_out[g]),
      .pc_plus4       (pc_plus4[g]),
      .pc_src         (pc_src),
      .jump           (jump)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count    (fcnt[g]),
      .redirect_count (rcnt[g])
`endif
    );
  end

  function automatic logic [31:0] rpc(int s);
    case (s)
      0:       return 32'h0000_0000;
      1:       return 32'h4000_0000;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (dut %0d, t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    pc_src         = 1'b0;
    jump           = 1'b0;
    rst_n          = 1'b0;
    #2;
    check_eq("rst_req_valid", 32'(req_valid[sel]), 32'h0);
    check_eq("rst_instr_valid", 32'(ivalid[sel]), 32'h0);
    check_eq("rst_instr", instr[sel], 32'h0);
    check_eq("rst_addr", addr[sel], rpc(sel));
`ifdef FETCH_STATS_EN
    check_eq("rst_fetch_count", fcnt[sel], 32'h0);
    check_eq("rst_redirect_count", rcnt[sel], 32'h0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !req_valid[sel]; i++) tick();
    check_eq("req_valid", 32'(req_valid[sel]), 32'h1);
  endtask

  task automatic fetch(logic [31:0] exp_addr, logic [31:0] data);
    wait_req();
    check_eq("req_addr", addr[sel], exp_addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check_eq("req_drop_in_wait", 32'(req_valid[sel]), 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("instr_valid", 32'(ivalid[sel]), 32'h1);
    check_eq("instr", instr[sel], data);
    check_eq("pc_out", pc_out[sel], exp_addr);
  endtask

  task automatic accept(logic ps, logic j);
    pc_src      = ps;
    jump        = j;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    jump        = 1'b0;
    check_eq("accept_clears_valid", 32'(ivalid[sel]), 32'h0);
    check_eq("accept_next_req", 32'(req_valid[sel]), 32'(!halt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // sequential fetch, jump within region, taken branch backwards, stall, halt
    sel = 0;
    do_reset();
    fetch(32'h0000_0000, 32'h0000_0020);
    check_eq("opcode_rtype", 32'(opcode[0]), 32'h00);
    check_eq("func_add", 32'(func[0]), 32'h20);
    check_eq("pc_plus4_0", pc_plus4[0], 32'h0000_0004);
    accept(1'b0, 1'b0);
    fetch(32'h0000_0004, 32'h2000_0001);
    accept(1'b0, 1'b0);
    fetch(32'h0000_0008, 32'h0800_0010);
    accept(1'b0, 1'b1);
    fetch(32'h0000_0040, 32'h1000_FFFE);
    check_eq("opcode_beq", 32'(opcode[0]), 32'h04);
    check_eq("pc_plus4_beq", pc_plus4[0], 32'h0000_0044);
    accept(1'b1, 1'b0);
    fetch(32'h0000_003C, 32'h1400_0003);

    // held instr must ignore stray responses and pc_src/jump while not accepted
    imem_rsp_valid = 1'b1;
    pc_src         = 1'b1;
    jump           = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_rsp_data = 32'hDEAD_0000 + 32'(i);
      tick();
      check_eq("stall_instr", instr[0], 32'h1400_0003);
      check_eq("stall_valid", 32'(ivalid[0]), 32'h1);
      check_eq("stall_no_req", 32'(req_valid[0]), 32'h0);
    end
    imem_rsp_valid = 1'b0;
    accept(1'b0, 1'b0);
`ifdef FETCH_STATS_EN
    check_eq("fetch_count", fcnt[0], 32'd5);
    check_eq("redirect_count", rcnt[0], 32'd2);
`endif
    fetch(32'h0000_0040, 32'h0000_0000);
    halt = 1'b1;
    accept(1'b0, 1'b0);
    tick();
    tick();
    check_eq("halt_idle_no_req", 32'(req_valid[0]), 32'h0);
    halt = 1'b0;
    tick();
    check_eq("resume_req", 32'(req_valid[0]), 32'h1);
    check_eq("resume_addr", addr[0], 32'h0000_0044);
    halt = 1'b1;
    tick();
    tick();
    check_eq("halt_in_req_holds", 32'(req_valid[0]), 32'h1);
    check_eq("halt_in_req_addr", addr[0], 32'h0000_0044);
    halt = 1'b0;

    // jump has priority over branch
    sel = 1;
    do_reset();
    fetch(32'h4000_0000, 32'h0800_0010);
    accept(1'b1, 1'b1);
    check_eq("jump_prio_addr", addr[1], 32'h4000_0040);

    // pc wraps past the top of the address space
    sel = 2;
    do_reset();
    fetch(32'hFFFF_FFFC, 32'h0000_0000);
    check_eq("pc_plus4_wrap", pc_plus4[2], 32'h0000_0000);
    accept(1'b0, 1'b0);
    check_eq("wrap_addr", addr[2], 32'h0000_0000);

    // reset while waiting: late response is dropped
    sel = 0;
    do_reset();
    wait_req();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_req", 32'(req_valid[0]), 32'h0);
    tick();
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("late_rsp_valid", 32'(ivalid[0]), 32'h0);
    check_eq("late_rsp_instr", instr[0], 32'h0);
    check_eq("post_rst_req", 32'(req_valid[0]), 32'h1);
    check_eq("post_rst_addr", addr[0], 32'h0000_0000);
    fetch(32'h0000_0000, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
